// File: rtl/memory_stage.sv
// ME pipeline stage: EX/ME register, data-memory load/store handshake,
// load-data formatting and the registered ME/WB interface toward writeback.
module memory_stage #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              rf_we_i,
    input  logic [ADDR_W-1:0] rf_waddr_i,
    input  logic              mem2rf_i,
    input  logic              mem_we_i,
    input  logic [2:0]        mem_size_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [DATA_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic              mem2rf_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [1:0]        fsm_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic              ex_valid;
    logic              ex_rf_we;
    logic [ADDR_W-1:0] ex_waddr;
    logic              ex_mem2rf;
    logic              ex_mem_we;
    logic [2:0]        ex_size;
    logic [DATA_W-1:0] ex_alu;
    logic [DATA_W-1:0] ex_sdata;

    logic [1:0]        state;
    logic [1:0]        state_next;

    logic              is_byte;
    logic              is_half;
    logic              is_word;
    logic              is_load;
    logic              mem_op;
    logic              misaligned;
    logic              access;
    logic              issuing;
    logic              mem_done;
    logic              retire;
    logic [1:0]        offset;
    logic [3:0]        be_base;
    logic [15:0]       lane;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] load_data;

    // Unlisted funct3 codes fall through to word size.
    assign offset     = ex_alu[1:0];
    assign is_byte    = (ex_size == 3'b000) || (ex_size == 3'b100);
    assign is_half    = (ex_size == 3'b001) || (ex_size == 3'b101);
    assign is_word    = !is_byte && !is_half;
    assign is_load    = ex_mem2rf && !ex_mem_we;
    assign mem_op     = ex_valid && (ex_mem2rf || ex_mem_we);
    assign misaligned = (is_half && offset[0]) || (is_word && (offset != 2'b00));
    assign access     = mem_op && !misaligned;

    // Handshake: dmem_req_o holds address/be/wdata stable until dmem_gnt_i; a
    // granted load then waits for dmem_rvalid_i, which may coincide with the grant.
    assign issuing  = access && (state != RESP);
    assign mem_done = ex_mem_we ? (issuing && dmem_gnt_i)
                                : ((issuing && dmem_gnt_i && dmem_rvalid_i) ||
                                   ((state == RESP) && dmem_rvalid_i));
    assign stall_o    = access && !mem_done;
    assign misalign_o = mem_op && misaligned;
    assign retire     = ex_valid && !stall_o && !misalign_o;

    always_comb begin
        be_base   = 4'b1111;
        wdata_rep = ex_sdata;
        if (is_byte) begin
            be_base   = 4'b0001;
            wdata_rep = {4{ex_sdata[7:0]}};
        end else if (is_half) begin
            be_base   = 4'b0011;
            wdata_rep = {2{ex_sdata[15:0]}};
        end
    end

    assign lane = 16'(dmem_rdata_i >> {offset, 3'b000});

    always_comb begin
        if (is_byte)
            load_data = ex_size[2] ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        else if (is_half)
            load_data = ex_size[2] ? {16'b0, lane} : {{16{lane[15]}}, lane};
        else
            load_data = dmem_rdata_i;
    end

    assign dmem_req_o   = issuing;
    assign dmem_we_o    = issuing && ex_mem_we;
    assign dmem_addr_o  = issuing ? {ex_alu[DATA_W-1:2], 2'b00} : '0;
    assign dmem_be_o    = issuing ? (be_base << offset) : 4'b0000;
    assign dmem_wdata_o = issuing ? wdata_rep : '0;
    assign fsm_state    = state;

    always_comb begin
        state_next = state;
        case (state)
            IDLE, REQ: begin
                if (!issuing)
                    state_next = IDLE;
                else if (!dmem_gnt_i)
                    state_next = REQ;
                else if (ex_mem_we || dmem_rvalid_i)
                    state_next = IDLE;
                else
                    state_next = RESP;
            end
            RESP:    if (dmem_rvalid_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_rf_we  <= 1'b0;
            ex_waddr  <= '0;
            ex_mem2rf <= 1'b0;
            ex_mem_we <= 1'b0;
            ex_size   <= 3'b000;
            ex_alu    <= '0;
            ex_sdata  <= '0;
        end else if (!stall_o) begin
            ex_valid  <= valid_i;
            ex_rf_we  <= rf_we_i;
            ex_waddr  <= rf_waddr_i;
            ex_mem2rf <= mem2rf_i;
            ex_mem_we <= mem_we_i;
            ex_size   <= mem_size_i;
            ex_alu    <= alu_result_i;
            ex_sdata  <= store_data_i;
        end
    end

    // Cycles without a retiring instruction write a bubble into ME/WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_o      <= 1'b0;
            rf_waddr_o   <= '0;
            mem2rf_o     <= 1'b0;
            mem_rdata_o  <= '0;
            alu_result_o <= '0;
        end else if (retire) begin
            rf_we_o      <= ex_rf_we && !ex_mem_we;
            rf_waddr_o   <= ex_waddr;
            mem2rf_o     <= is_load;
            mem_rdata_o  <= is_load ? load_data : '0;
            alu_result_o <= ex_alu;
        end else begin
            rf_we_o  <= 1'b0;
            mem2rf_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed vector table, hand-written multi-cycle
// sequences and a randomized run against a behavioural model.
module tb_memory_stage;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int WB_W   = 1 + ADDR_W + 1 + DATA_W + DATA_W;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i;
    logic              rf_we_i;
    logic [ADDR_W-1:0] rf_waddr_i;
    logic              mem2rf_i;
    logic              mem_we_i;
    logic [2:0]        mem_size_i;
    logic [DATA_W-1:0] alu_result_i;
    logic [DATA_W-1:0] store_data_i;
    logic              dmem_req_o;
    logic              dmem_we_o;
    logic [DATA_W-1:0] dmem_addr_o;
    logic [3:0]        dmem_be_o;
    logic [DATA_W-1:0] dmem_wdata_o;
    logic              dmem_gnt_i;
    logic              dmem_rvalid_i;
    logic [DATA_W-1:0] dmem_rdata_i;
    logic              stall_o;
    logic              misalign_o;
    logic              rf_we_o;
    logic [ADDR_W-1:0] rf_waddr_o;
    logic              mem2rf_o;
    logic [DATA_W-1:0] mem_rdata_o;
    logic [DATA_W-1:0] alu_result_o;
    logic [1:0]        fsm_state;

    memory_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .rf_we_i(rf_we_i),
        .rf_waddr_i(rf_waddr_i), .mem2rf_i(mem2rf_i), .mem_we_i(mem_we_i),
        .mem_size_i(mem_size_i), .alu_result_i(alu_result_i),
        .store_data_i(store_data_i), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o), .misalign_o(misalign_o), .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o), .mem2rf_o(mem2rf_o), .mem_rdata_o(mem_rdata_o),
        .alu_result_o(alu_result_o), .fsm_state(fsm_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    typedef struct {
        logic              v;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic              ld;
        logic              st;
        logic [2:0]        sz;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] sd;
    } instr_t;

    typedef struct {
        logic        ld;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rd;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ld_val;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    logic [WB_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input instr_t t);
        valid_i      = t.v;
        rf_we_i      = t.we;
        rf_waddr_i   = t.wa;
        mem2rf_i     = t.ld;
        mem_we_i     = t.st;
        mem_size_i   = t.sz;
        alu_result_i = t.alu;
        store_data_i = t.sd;
    endtask

    task automatic issue(input instr_t t);
        instr_t idle_i;
        idle_i = '{default: '0};
        drive(t);
        tick();
        drive(idle_i);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},    dmem_req_o,   0);
        check({tag, "_we"},     dmem_we_o,    0);
        check({tag, "_addr"},   dmem_addr_o,  0);
        check({tag, "_be"},     dmem_be_o,    0);
        check({tag, "_wdata"},  dmem_wdata_o, 0);
        check({tag, "_stall"},  stall_o,      0);
        check({tag, "_mis"},    misalign_o,   0);
        check({tag, "_rfwe"},   rf_we_o,      0);
        check({tag, "_waddr"},  rf_waddr_o,   0);
        check({tag, "_mem2rf"}, mem2rf_o,     0);
        check({tag, "_rdata"},  mem_rdata_o,  0);
        check({tag, "_alu"},    alu_result_o, 0);
        check({tag, "_state"},  fsm_state,    S_IDLE);
    endtask

    // Behavioural reference: access width in bytes, then plain arithmetic.
    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit model_mis(input logic [2:0] sz, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] sz, input logic [31:0] a);
        int v;
        v = ((1 << nbytes(sz)) - 1) << int'(a[1:0]);
        return 4'(v);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] sz, input logic [31:0] sd);
        int nb;
        longint lane;
        longint r;
        nb   = nbytes(sz);
        lane = longint'(sd) % (longint'(1) << (8 * nb));
        r    = 0;
        for (int i = 0; i < 4 / nb; i++)
            r = r | (lane << (8 * nb * i));
        return 32'(r);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a,
                                               input logic [31:0] rd);
        int nb;
        longint v;
        nb = nbytes(sz);
        v  = (longint'(rd) >> (8 * int'(a[1:0]))) % (longint'(1) << (8 * nb));
        if ((sz == 3'd0 || sz == 3'd1) && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return 32'(v);
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int k;
        t.v   = ($urandom_range(0, 9) != 0);
        k     = $urandom_range(0, 2);
        t.ld  = (k == 1);
        t.st  = (k == 2);
        t.sz  = 3'($urandom_range(0, 7));
        t.alu = $urandom;
        if ((t.ld || t.st) && $urandom_range(0, 3) != 0) begin
            if (nbytes(t.sz) == 2) t.alu[0] = 1'b0;
            if (nbytes(t.sz) == 4) t.alu[1:0] = 2'b00;
        end
        t.we = t.st ? 1'b0 : 1'($urandom_range(0, 1));
        t.wa = ADDR_W'($urandom_range(0, 31));
        t.sd = $urandom;
        return t;
    endfunction

    vec_t vecs[15];

    initial begin
        instr_t t;
        instr_t cur;
        instr_t nxt;
        instr_t idle_i;
        logic [WB_W-1:0] rec;
        logic [1:0] st_exp[4];
        int stall_cycles;
        bit ph;
        bit cur_mem, cur_mis, acc, e_req, g, rv, done;
        logic [31:0] rd;

        vecs[0]  = '{1'b1, 3'd0, 32'h103, 32'h0,         32'h80FF_0000, 1'b0, 4'b1000, 32'h0,         32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 3'd4, 32'h103, 32'h0,         32'h80FF_0000, 1'b0, 4'b1000, 32'h0,         32'h0000_0080};
        vecs[2]  = '{1'b1, 3'd1, 32'h102, 32'h0,         32'h80FF_1234, 1'b0, 4'b1100, 32'h0,         32'hFFFF_80FF};
        vecs[3]  = '{1'b1, 3'd5, 32'h102, 32'h0,         32'h80FF_1234, 1'b0, 4'b1100, 32'h0,         32'h0000_80FF};
        vecs[4]  = '{1'b1, 3'd1, 32'h100, 32'h0,         32'h1234_8001, 1'b0, 4'b0011, 32'h0,         32'hFFFF_8001};
        vecs[5]  = '{1'b1, 3'd2, 32'h204, 32'h0,         32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 3'd0, 32'h101, 32'h0,         32'h0000_7F00, 1'b0, 4'b0010, 32'h0,         32'h0000_007F};
        vecs[7]  = '{1'b0, 3'd0, 32'h102, 32'h1234_56AB, 32'h0,         1'b0, 4'b0100, 32'hABAB_ABAB, 32'h0};
        vecs[8]  = '{1'b0, 3'd1, 32'h202, 32'hAAAA_BEEF, 32'h0,         1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
        vecs[9]  = '{1'b0, 3'd2, 32'h300, 32'hCAFE_F00D, 32'h0,         1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[10] = '{1'b1, 3'd2, 32'h005, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[11] = '{1'b1, 3'd1, 32'h001, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[12] = '{1'b1, 3'd3, 32'h008, 32'h0,         32'h1122_3344, 1'b0, 4'b1111, 32'h0,         32'h1122_3344};
        vecs[13] = '{1'b1, 3'd7, 32'h00A, 32'h0,         32'h0,         1'b1, 4'b0000, 32'h0,         32'h0};
        vecs[14] = '{1'b1, 3'd4, 32'h102, 32'h0,         32'h00AB_0000, 1'b0, 4'b0100, 32'h0,         32'h0000_00AB};

        idle_i = '{default: '0};
        drive(idle_i);
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_all_zero("reset");

        // ADD: one-cycle latency, no stall.
        t = '{v: 1'b1, we: 1'b1, wa: 5'd5, ld: 1'b0, st: 1'b0, sz: 3'd0, alu: 32'h1234, sd: 32'h0};
        issue(t);
        #1;
        check("add_stall", stall_o, 0);
        check("add_req", dmem_req_o, 0);
        tick();
        check("add_rfwe", rf_we_o, 1);
        check("add_waddr", rf_waddr_o, 5);
        check("add_alu", alu_result_o, 32'h1234);
        check("add_mem2rf", mem2rf_o, 0);
        check("add_stall2", stall_o, 0);
        tick();
        check("add_bubble", rf_we_o, 0);

        // Vector table, zero-wait memory.
        for (int i = 0; i < 15; i++) begin
            t = '{v: 1'b1, we: vecs[i].ld, wa: ADDR_W'(i + 1), ld: vecs[i].ld, st: !vecs[i].ld,
                  sz: vecs[i].sz, alu: vecs[i].addr, sd: vecs[i].sd};
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            issue(t);
            #1;
            check($sformatf("vec%0d_req", i), dmem_req_o, !vecs[i].mis);
            check($sformatf("vec%0d_mis", i), misalign_o, vecs[i].mis);
            if (!vecs[i].mis) begin
                check($sformatf("vec%0d_be", i), dmem_be_o, vecs[i].be);
                check($sformatf("vec%0d_addr", i), dmem_addr_o, {vecs[i].addr[31:2], 2'b00});
                check($sformatf("vec%0d_we", i), dmem_we_o, !vecs[i].ld);
                if (!vecs[i].ld)
                    check($sformatf("vec%0d_wdata", i), dmem_wdata_o, vecs[i].wdata);
                dmem_gnt_i    = 1'b1;
                dmem_rvalid_i = vecs[i].ld;
                dmem_rdata_i  = vecs[i].rd;
            end
            #1;
            check($sformatf("vec%0d_stall", i), stall_o, 0);
            tick();
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            check($sformatf("vec%0d_rfwe", i), rf_we_o, vecs[i].ld && !vecs[i].mis);
            check($sformatf("vec%0d_mis_end", i), misalign_o, 0);
            if (vecs[i].ld && !vecs[i].mis) begin
                check($sformatf("vec%0d_rdata", i), mem_rdata_o, vecs[i].ld_val);
                check($sformatf("vec%0d_waddr", i), rf_waddr_o, i + 1);
            end
        end

        // LB at 0x103: two wait cycles, grant, then read data.
        t = '{v: 1'b1, we: 1'b1, wa: 5'd7, ld: 1'b1, st: 1'b0, sz: 3'd0, alu: 32'h103, sd: 32'h0};
        st_exp = '{S_IDLE, S_REQ, S_REQ, S_RESP};
        stall_cycles = 0;
        issue(t);
        for (int c = 0; c < 4; c++) begin
            dmem_gnt_i    = (c == 2);
            dmem_rvalid_i = (c == 3);
            dmem_rdata_i  = 32'h80FF_0000;
            #1;
            if (stall_o) stall_cycles++;
            check($sformatf("lbw%0d_state", c), fsm_state, st_exp[c]);
            check($sformatf("lbw%0d_req", c), dmem_req_o, c < 3);
            check($sformatf("lbw%0d_stall", c), stall_o, c < 3);
            if (c < 3) begin
                check($sformatf("lbw%0d_be", c), dmem_be_o, 4'b1000);
                check($sformatf("lbw%0d_addr", c), dmem_addr_o, 32'h100);
            end
            tick();
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            if (c < 3) check($sformatf("lbw%0d_bubble", c), rf_we_o, 0);
        end
        check("lbw_stall_cycles", stall_cycles, 3);
        check("lbw_rfwe", rf_we_o, 1);
        check("lbw_waddr", rf_waddr_o, 7);
        check("lbw_rdata", mem_rdata_o, 32'hFFFF_FF80);
        check("lbw_mem2rf", mem2rf_o, 1);
        check("lbw_state_end", fsm_state, S_IDLE);

        // Back-to-back zero-wait loads.
        t = '{v: 1'b1, we: 1'b1, wa: 5'd10, ld: 1'b1, st: 1'b0, sz: 3'd2, alu: 32'h10, sd: 32'h0};
        drive(t);
        tick();
        t = '{v: 1'b1, we: 1'b1, wa: 5'd11, ld: 1'b1, st: 1'b0, sz: 3'd2, alu: 32'h20, sd: 32'h0};
        drive(t);
        dmem_gnt_i    = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h1111_AAAA;
        #1;
        check("b2b_a_req", dmem_req_o, 1);
        check("b2b_a_addr", dmem_addr_o, 32'h10);
        check("b2b_a_stall", stall_o, 0);
        tick();
        drive(idle_i);
        dmem_rdata_i = 32'h2222_BBBB;
        check("b2b_a_waddr", rf_waddr_o, 10);
        check("b2b_a_rdata", mem_rdata_o, 32'h1111_AAAA);
        #1;
        check("b2b_b_req", dmem_req_o, 1);
        check("b2b_b_addr", dmem_addr_o, 32'h20);
        check("b2b_b_stall", stall_o, 0);
        tick();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        check("b2b_b_rfwe", rf_we_o, 1);
        check("b2b_b_waddr", rf_waddr_o, 11);
        check("b2b_b_rdata", mem_rdata_o, 32'h2222_BBBB);

        // Reset while waiting for read data; late rvalid must be ignored.
        t = '{v: 1'b1, we: 1'b1, wa: 5'd9, ld: 1'b1, st: 1'b0, sz: 3'd2, alu: 32'h40, sd: 32'h0};
        issue(t);
        dmem_gnt_i = 1'b1;
        #1;
        check("rst_grant_stall", stall_o, 1);
        tick();
        dmem_gnt_i = 1'b0;
        #1;
        check("rst_resp_state", fsm_state, S_RESP);
        check("rst_resp_stall", stall_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hFFFF_FFFF;
        #1;
        check("late_rv_stall", stall_o, 0);
        check("late_rv_req", dmem_req_o, 0);
        tick();
        dmem_rvalid_i = 1'b0;
        check("late_rv_rfwe", rf_we_o, 0);
        check("late_rv_mem2rf", mem2rf_o, 0);
        check("late_rv_rdata", mem_rdata_o, 0);
        check("late_rv_state", fsm_state, S_IDLE);

        // Randomized run against the behavioural model.
        cur = idle_i;
        ph  = 1'b0;
        nxt = rand_instr();
        drive(nxt);
        for (int c = 0; c < 3000; c++) begin
            cur_mem = cur.v && (cur.ld || cur.st);
            cur_mis = cur_mem && model_mis(cur.sz, cur.alu);
            acc     = cur_mem && !cur_mis;
            e_req   = acc && !ph;
            g       = e_req && ($urandom_range(0, 1) == 1);
            rv      = acc && cur.ld && (ph || g) && ($urandom_range(0, 1) == 1);
            rd      = $urandom;
            dmem_gnt_i    = g;
            dmem_rvalid_i = rv;
            dmem_rdata_i  = rd;
            done = !acc || (cur.st ? g : rv);
            #1;
            check("rnd_req", dmem_req_o, e_req);
            check("rnd_stall", stall_o, !done);
            check("rnd_mis", misalign_o, cur_mis);
            if (e_req) begin
                check("rnd_addr", dmem_addr_o, {cur.alu[31:2], 2'b00});
                check("rnd_be", dmem_be_o, model_be(cur.sz, cur.alu));
                check("rnd_we", dmem_we_o, cur.st);
                if (cur.st) check("rnd_wdata", dmem_wdata_o, model_wdata(cur.sz, cur.sd));
            end
            if (cur.v && !cur_mis && done)
                exp_q.push_back({cur.we && !cur.st, cur.wa, cur.ld,
                                 cur.ld ? model_load(cur.sz, cur.alu, rd) : 32'h0, cur.alu});
            tick();
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
            if (exp_q.size() > 0) begin
                rec = exp_q.pop_front();
                check("rnd_wb_rfwe", rf_we_o, rec[WB_W-1]);
                check("rnd_wb_waddr", rf_waddr_o, rec[WB_W-2 -: ADDR_W]);
                check("rnd_wb_mem2rf", mem2rf_o, rec[2*DATA_W]);
                check("rnd_wb_rdata", mem_rdata_o, rec[2*DATA_W-1 -: DATA_W]);
                check("rnd_wb_alu", alu_result_o, rec[DATA_W-1:0]);
            end else begin
                check("rnd_bubble_rfwe", rf_we_o, 0);
                check("rnd_bubble_mem2rf", mem2rf_o, 0);
            end
            if (!done) begin
                if (cur.ld && g && !rv) ph = 1'b1;
            end else begin
                cur = nxt;
                ph  = 1'b0;
                nxt = rand_instr();
                drive(nxt);
            end
        end
        drive(idle_i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
